// File: rtl/mpc_pkg.sv
// Shared fixed-point types, solver FSM states and abs/saturation helpers.
// FX_W is the solver word width; blocks using fx_t assume DATA_WIDTH == FX_W.
package mpc_pkg;

  localparam int FX_W = 16;

  typedef logic signed [FX_W-1:0] fx_t;
  typedef logic        [FX_W-1:0] ures_t;

  typedef enum logic [2:0] {
    IDLE,
    U_ISSUE,
    U_WAIT,
    U_UPD,
    X_ISSUE,
    X_WAIT,
    X_UPD,
    DONE_STATE
  } state_t;

  localparam fx_t FX_MAX = {1'b0, {(FX_W-1){1'b1}}};
  localparam fx_t FX_MIN = {1'b1, {(FX_W-1){1'b0}}};
  localparam logic signed [FX_W+1:0] WIDE_MAX = (FX_W+2)'(FX_MAX);
  localparam logic signed [FX_W+1:0] WIDE_MIN = (FX_W+2)'(FX_MIN);

  // Magnitude of a one-bit-wider difference, clipped to the unsigned word range.
  function automatic ures_t abs_clip(input logic signed [FX_W:0] d);
    logic [FX_W:0] mag;
    mag = d[FX_W] ? -d : d;
    return mag[FX_W] ? '1 : mag[FX_W-1:0];
  endfunction

  function automatic fx_t sat_fx(input logic signed [FX_W+1:0] s);
    if (s > WIDE_MAX)      return FX_MAX;
    else if (s < WIDE_MIN) return FX_MIN;
    else                   return s[FX_W-1:0];
  endfunction

  function automatic logic sat_ovf(input logic signed [FX_W+1:0] s);
    return (s > WIDE_MAX) || (s < WIDE_MIN);
  endfunction

endpackage

// File: rtl/dual_elem_update.sv
// Combinational per-element dual update: dual_new = dual_old + (a - b), plus |a - b|.
// With DUAL_UPDATE_SAT_EN the result saturates and overflow flags the clip; otherwise it wraps.
module dual_elem_update
  import mpc_pkg::*;
(
  input  fx_t   a,
  input  fx_t   b,
  input  fx_t   dual_old,
  output fx_t   dual_new,
  output ures_t abs_diff
`ifdef DUAL_UPDATE_SAT_EN
  ,
  output logic  overflow
`endif
);

  logic signed [FX_W:0] d;

  assign d        = {a[FX_W-1], a} - {b[FX_W-1], b};
  assign abs_diff = abs_clip(d);

`ifdef DUAL_UPDATE_SAT_EN
  logic signed [FX_W+1:0] sum;

  assign sum      = {{2{dual_old[FX_W-1]}}, dual_old} + {d[FX_W], d};
  assign dual_new = sat_fx(sum);
  assign overflow = sat_ovf(sum);
`else
  // Only the low word of the wide sum survives, so the carry-out bits are never built.
  assign dual_new = dual_old + d[FX_W-1:0];
`endif

endmodule

// File: rtl/dual_update.sv
// ADMM scaled-dual update: sweeps y += (u - z) then g += (x - v), tracking max |residual|.
// Optional DUAL_UPDATE_SAT_EN: saturating dual update plus sticky sat_flag output.
module dual_update
  import mpc_pkg::*;
#(
  parameter int STATE_DIM    = 12,
  parameter int INPUT_DIM    = 4,
  parameter int HORIZON      = 30,
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           active_horizon,
  output logic [ADDR_WIDTH-1:0] u_addr,
  input  logic [DATA_WIDTH-1:0] u_data,
  input  logic [DATA_WIDTH-1:0] z_data,
  input  logic [DATA_WIDTH-1:0] y_data,
  output logic [DATA_WIDTH-1:0] y_wrdata,
  output logic                  y_wren,
  output logic [ADDR_WIDTH-1:0] x_addr,
  input  logic [DATA_WIDTH-1:0] x_data,
  input  logic [DATA_WIDTH-1:0] v_data,
  input  logic [DATA_WIDTH-1:0] g_data,
  output logic [DATA_WIDTH-1:0] g_wrdata,
  output logic                  g_wren,
  output logic [DATA_WIDTH-1:0] pri_res_u,
  output logic [DATA_WIDTH-1:0] pri_res_x,
  output logic                  done
`ifdef DUAL_UPDATE_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam int WW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WW-1:0]         WAIT_LAST = WW'(READ_LATENCY - 1);
  localparam logic [31:0]           HOR_32    = 32'(HORIZON);
  localparam logic [ADDR_WIDTH-1:0] HOR_A     = ADDR_WIDTH'(HORIZON);
  localparam logic [ADDR_WIDTH-1:0] IN_DIM_A  = ADDR_WIDTH'(INPUT_DIM);
  localparam logic [ADDR_WIDTH-1:0] ST_DIM_A  = ADDR_WIDTH'(STATE_DIM);
  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] h_clamp, nu_in, nx_in;
  logic [ADDR_WIDTH-1:0] nu_q, nx_q, u_idx, x_idx;
  logic [WW-1:0]         wait_cnt;
  logic                  u_last, x_last;
  fx_t                   y_new, g_new;
  ures_t                 u_abs, x_abs;
`ifdef DUAL_UPDATE_SAT_EN
  logic                  u_ovf, x_ovf;
`endif

  // Input trajectory stops one step short of the horizon; states span all of it.
  assign h_clamp = (active_horizon > HOR_32) ? HOR_A : active_horizon[ADDR_WIDTH-1:0];
  assign nu_in   = (h_clamp <= ONE_A) ? '0 : (h_clamp - ONE_A) * IN_DIM_A;
  assign nx_in   = h_clamp * ST_DIM_A;
  assign u_last  = (u_idx == nu_q - ONE_A);
  assign x_last  = (x_idx == nx_q - ONE_A);

  dual_elem_update u_upd (
    .a        (u_data),
    .b        (z_data),
    .dual_old (y_data),
    .dual_new (y_new),
    .abs_diff (u_abs)
`ifdef DUAL_UPDATE_SAT_EN
    ,
    .overflow (u_ovf)
`endif
  );

  dual_elem_update x_upd (
    .a        (x_data),
    .b        (v_data),
    .dual_old (g_data),
    .dual_new (g_new),
    .abs_diff (x_abs)
`ifdef DUAL_UPDATE_SAT_EN
    ,
    .overflow (x_ovf)
`endif
  );

  // Strobes decode straight from the state register so reset kills them at once.
  assign y_wren   = (state_q == U_UPD);
  assign g_wren   = (state_q == X_UPD);
  assign y_wrdata = y_wren ? y_new : '0;
  assign g_wrdata = g_wren ? g_new : '0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start) begin
          if (nu_in != '0)      state_d = U_ISSUE;
          else if (nx_in != '0) state_d = X_ISSUE;
          else                  state_d = DONE_STATE;
        end
      U_ISSUE:    state_d = U_WAIT;
      U_WAIT:     if (wait_cnt == WAIT_LAST) state_d = U_UPD;
      U_UPD:      state_d = u_last ? X_ISSUE : U_ISSUE;
      X_ISSUE:    state_d = X_WAIT;
      X_WAIT:     if (wait_cnt == WAIT_LAST) state_d = X_UPD;
      X_UPD:      state_d = x_last ? DONE_STATE : X_ISSUE;
      DONE_STATE: if (!start) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_addr    <= '0;
      x_addr    <= '0;
      u_idx     <= '0;
      x_idx     <= '0;
      nu_q      <= '0;
      nx_q      <= '0;
      wait_cnt  <= '0;
      pri_res_u <= '0;
      pri_res_x <= '0;
      done      <= 1'b0;
`ifdef DUAL_UPDATE_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      done <= (state_d == DONE_STATE);
      unique case (state_q)
        IDLE:
          if (start) begin
            pri_res_u <= '0;
            pri_res_x <= '0;
            u_idx     <= '0;
            x_idx     <= '0;
            nu_q      <= nu_in;
            nx_q      <= nx_in;
`ifdef DUAL_UPDATE_SAT_EN
            sat_flag  <= 1'b0;
`endif
          end
        U_ISSUE: begin
          u_addr   <= u_idx;
          wait_cnt <= '0;
        end
        X_ISSUE: begin
          x_addr   <= x_idx;
          wait_cnt <= '0;
        end
        U_WAIT, X_WAIT: wait_cnt <= wait_cnt + 1'b1;
        U_UPD: begin
          u_idx <= u_idx + ONE_A;
          if (u_abs > pri_res_u) pri_res_u <= u_abs;
`ifdef DUAL_UPDATE_SAT_EN
          if (u_ovf) sat_flag <= 1'b1;
`endif
        end
        X_UPD: begin
          x_idx <= x_idx + ONE_A;
          if (x_abs > pri_res_x) pri_res_x <= x_abs;
`ifdef DUAL_UPDATE_SAT_EN
          if (x_ovf) sat_flag <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_update.sv
// Directed bench for dual_update at default parameters with latency-2 memory models.
// Expected values are hand-computed; DUAL_UPDATE_SAT_EN selects the saturating expectations.
module tb_dual_update;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] active_horizon;
  logic [8:0]  u_addr, x_addr;
  logic [15:0] u_data, z_data, y_data, x_data, v_data, g_data;
  logic [15:0] y_wrdata, g_wrdata, pri_res_u, pri_res_x;
  logic        y_wren, g_wren, done;
`ifdef DUAL_UPDATE_SAT_EN
  logic        sat_flag;
`endif

  logic [15:0] u_mem [512];
  logic [15:0] z_mem [512];
  logic [15:0] y_mem [512];
  logic [15:0] x_mem [512];
  logic [15:0] v_mem [512];
  logic [15:0] g_mem [512];
  logic [15:0] u_p1, u_p2, z_p1, z_p2, y_p1, y_p2;
  logic [15:0] x_p1, x_p2, v_p1, v_p2, g_p1, g_p2;

  int n_checks = 0;
  int n_fail   = 0;
  int y_cnt, g_cnt, y_next, g_next, y_order_err, g_order_err, both_err;
  int lat;

  always #5 clk = ~clk;

  dual_update dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .active_horizon (active_horizon),
    .u_addr         (u_addr),
    .u_data         (u_data),
    .z_data         (z_data),
    .y_data         (y_data),
    .y_wrdata       (y_wrdata),
    .y_wren         (y_wren),
    .x_addr         (x_addr),
    .x_data         (x_data),
    .v_data         (v_data),
    .g_data         (g_data),
    .g_wrdata       (g_wrdata),
    .g_wren         (g_wren),
    .pri_res_u      (pri_res_u),
    .pri_res_x      (pri_res_x),
    .done           (done)
`ifdef DUAL_UPDATE_SAT_EN
    ,
    .sat_flag       (sat_flag)
`endif
  );

  // Two register stages behind the DUT address register give READ_LATENCY = 2.
  always @(posedge clk) begin
    u_p1 <= u_mem[u_addr]; u_p2 <= u_p1;
    z_p1 <= z_mem[u_addr]; z_p2 <= z_p1;
    y_p1 <= y_mem[u_addr]; y_p2 <= y_p1;
    x_p1 <= x_mem[x_addr]; x_p2 <= x_p1;
    v_p1 <= v_mem[x_addr]; v_p2 <= v_p1;
    g_p1 <= g_mem[x_addr]; g_p2 <= g_p1;
    if (y_wren) y_mem[u_addr] <= y_wrdata;
    if (g_wren) g_mem[x_addr] <= g_wrdata;
  end

  assign u_data = u_p2;
  assign z_data = z_p2;
  assign y_data = y_p2;
  assign x_data = x_p2;
  assign v_data = v_p2;
  assign g_data = g_p2;

  always @(negedge clk) begin
    if (y_wren) begin
      if (32'(u_addr) != 32'(y_next)) y_order_err++;
      y_next++;
      y_cnt++;
    end
    if (g_wren) begin
      if (32'(x_addr) != 32'(g_next)) g_order_err++;
      g_next++;
      g_cnt++;
    end
    if (y_wren && g_wren) both_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) begin
      u_mem[i] <= '0; z_mem[i] <= '0; y_mem[i] <= '0;
      x_mem[i] <= '0; v_mem[i] <= '0; g_mem[i] <= '0;
    end
  endtask

  // Raise start at a falling edge; lat is cycles from the first rising edge (E0) to done.
  task automatic sweep(input logic [31:0] h, input int budget, output int l);
    int cyc;
    @(negedge clk);
    y_cnt = 0; g_cnt = 0; y_next = 0; g_next = 0;
    y_order_err = 0; g_order_err = 0; both_err = 0;
    active_horizon = h;
    start = 1'b1;
    cyc = 0;
    l = -1;
    while (cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        l = cyc - 1;
        break;
      end
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic release_start(input string tag);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check(tag, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    start = 1'b0;
    active_horizon = '0;
    clear_mem();
    #23;
    check("rst_done", 32'(done), 32'd0);
    check("rst_y_wren", 32'(y_wren), 32'd0);
    check("rst_g_wren", 32'(g_wren), 32'd0);
    check("rst_u_addr", 32'(u_addr), 32'd0);
    check("rst_pri_res_x", 32'(pri_res_x), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single nonzero input element: y = 0x40 + (0x180 - 0x100).
    clear_mem();
    u_mem[0] <= 16'h0180; z_mem[0] <= 16'h0100; y_mem[0] <= 16'h0040;
    sweep(32'd2, 500, lat);
    check("h2_latency", 32'(lat), 32'd112);
    check("h2_y0", 32'(y_mem[0]), 32'h00C0);
    check("h2_y1", 32'(y_mem[1]), 32'h0000);
    check("h2_pri_res_u", 32'(pri_res_u), 32'h0080);
    check("h2_pri_res_x", 32'(pri_res_x), 32'h0000);
    check("h2_y_writes", 32'(y_cnt), 32'd4);
    check("h2_g_writes", 32'(g_cnt), 32'd24);
`ifdef DUAL_UPDATE_SAT_EN
    check("h2_sat_flag", 32'(sat_flag), 32'd0);
`endif
    repeat (5) @(posedge clk);
    #1;
    check("hold_done", 32'(done), 32'd1);
    check("hold_pri_res_u", 32'(pri_res_u), 32'h0080);
    release_start("h2_done_drop");

    // Full defaults, H=3, zero memories.
    clear_mem();
    sweep(32'd3, 500, lat);
    check("h3_latency", 32'(lat), 32'd176);
    check("h3_y_writes", 32'(y_cnt), 32'd8);
    check("h3_g_writes", 32'(g_cnt), 32'd36);
    check("h3_y_order", 32'(y_order_err), 32'd0);
    check("h3_g_order", 32'(g_order_err), 32'd0);
    check("h3_one_wren", 32'(both_err), 32'd0);
    check("h3_pri_res_u", 32'(pri_res_u), 32'd0);
    release_start("h3_done_drop");

    sweep(32'd1, 500, lat);
    check("h1_latency", 32'(lat), 32'd48);
    check("h1_y_writes", 32'(y_cnt), 32'd0);
    check("h1_g_writes", 32'(g_cnt), 32'd12);
    release_start("h1_done_drop");

    sweep(32'd0, 50, lat);
    check("h0_latency", 32'(lat), 32'd0);
    check("h0_y_writes", 32'(y_cnt), 32'd0);
    check("h0_g_writes", 32'(g_cnt), 32'd0);
    release_start("h0_done_drop");

    sweep(32'd100, 3000, lat);
    check("h100_latency", 32'(lat), 32'd1904);
    check("h100_y_writes", 32'(y_cnt), 32'd116);
    check("h100_g_writes", 32'(g_cnt), 32'd360);
    check("h100_g_order", 32'(g_order_err), 32'd0);
    check("h100_one_wren", 32'(both_err), 32'd0);
    release_start("h100_done_drop");

    // Overflow: 0x7F00 + 0x0200, and 0 + (0x8000 - 0x7FFF) = 0 - 65535.
    clear_mem();
    u_mem[0] <= 16'h0200; y_mem[0] <= 16'h7F00;
    u_mem[1] <= 16'h8000; z_mem[1] <= 16'h7FFF;
    sweep(32'd2, 500, lat);
`ifdef DUAL_UPDATE_SAT_EN
    check("ovf_y0", 32'(y_mem[0]), 32'h7FFF);
    check("ovf_y1", 32'(y_mem[1]), 32'h8000);
    check("ovf_sat_flag", 32'(sat_flag), 32'd1);
`else
    check("ovf_y0", 32'(y_mem[0]), 32'h8100);
    check("ovf_y1", 32'(y_mem[1]), 32'h0001);
`endif
    check("ovf_pri_res_u", 32'(pri_res_u), 32'hFFFF);
    release_start("ovf_done_drop");

    // Max tracking over |x - v| = 0x10, 0x300, 0x20, 0x5 with mixed signs.
    clear_mem();
    x_mem[0] <= 16'h0010;
    v_mem[1] <= 16'h0300;
    v_mem[2] <= 16'h0020;
    x_mem[3] <= 16'h0005; g_mem[3] <= 16'h0100;
    sweep(32'd1, 500, lat);
    check("max_pri_res_x", 32'(pri_res_x), 32'h0300);
    check("max_pri_res_u", 32'(pri_res_u), 32'h0000);
    check("max_g0", 32'(g_mem[0]), 32'h0010);
    check("max_g1", 32'(g_mem[1]), 32'hFD00);
    check("max_g2", 32'(g_mem[2]), 32'hFFE0);
    check("max_g3", 32'(g_mem[3]), 32'h0105);
    release_start("max_done_drop");

    // Reset asserted while the third state element is being written.
    clear_mem();
    x_mem[0] <= 16'h0010;
    x_mem[2] <= 16'h0040;
    @(negedge clk);
    active_horizon = 32'd1;
    start = 1'b1;
    w = 0;
    while (!(g_wren && x_addr == 9'd2) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("rst_mid_reached", 32'(g_wrdata), 32'h0040);
    rst = 1'b1;
    #1;
    check("rst_mid_g_wren", 32'(g_wren), 32'd0);
    check("rst_mid_y_wren", 32'(y_wren), 32'd0);
    check("rst_mid_g_wrdata", 32'(g_wrdata), 32'd0);
    check("rst_mid_x_addr", 32'(x_addr), 32'd0);
    check("rst_mid_pri_res_x", 32'(pri_res_x), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
